// File: rtl/cordic_iter_ctrl.sv
// Iteration controller for a CORDIC engine whose shift/add ALU lives in a
// separate stage. The controller latches an operation, feeds the ALU one
// iteration at a time (operands, shifted operands, ATAN step), captures the
// returned vector/angle and presents the final result with a ready/valid
// handshake.
// Optional feature: define CORDIC_EARLY_EXIT_EN to finish as soon as the
// accumulated angle lands exactly on the target.
// W is supported up to 64; the ATAN table is scaled from its 32-bit form.
module cordic_iter_ctrl #(
  parameter int ITER = 16,
  parameter int W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic [W-1:0]        target_in,
  input  logic [3:0]          select_in,
  output logic signed [W-1:0] x_init,
  output logic signed [W-1:0] y_init,
  output logic signed [W-1:0] x_shift,
  output logic signed [W-1:0] y_shift,
  output logic [W-1:0]        angle,
  output logic [W-1:0]        delta_angle,
  output logic [W-1:0]        target_angle,
  output logic [3:0]          select,
  output logic                valid,
  input  logic signed [W-1:0] x_out,
  input  logic signed [W-1:0] y_out,
  input  logic [W-1:0]        angle_out,
  input  logic                ALU_valid_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W-1:0]        x_res,
  output logic [W-1:0]        y_res,
  output logic [W-1:0]        angle_res,
  output logic [5:0]          iter_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

  // atan(2^-i) with a full turn mapped to 2^32
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  state_t              state_reg, state_next;
  logic signed [W-1:0] x_reg, x_next;
  logic signed [W-1:0] y_reg, y_next;
  logic [W-1:0]        angle_reg, angle_next;
  logic [W-1:0]        target_reg, target_next;
  logic [3:0]          select_reg, select_next;
  logic [5:0]          iter_reg, iter_next;
  logic                last_iter;

  logic [W-1:0] atan_rom [32];

  // Rescale each table entry to the datapath width (top W bits of the 32-bit turn)
  for (genvar gi = 0; gi < 32; gi++) begin : g_atan
    assign atan_rom[gi] = W'({ATAN32[gi], 32'h0} >> (64 - W));
  end

  assign last_iter = (iter_reg == 6'(ITER - 1));

  assign x_res     = x_reg;
  assign y_res     = y_reg;
  assign angle_res = angle_reg;
  assign iter_cnt  = iter_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Operand/result registers; all cleared by reset so an aborted op leaves nothing behind
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      angle_reg  <= '0;
      target_reg <= '0;
      select_reg <= '0;
      iter_reg   <= '0;
    end else begin
      x_reg      <= x_next;
      y_reg      <= y_next;
      angle_reg  <= angle_next;
      target_reg <= target_next;
      select_reg <= select_next;
      iter_reg   <= iter_next;
    end
  end

  // Next-state, register updates and ALU operand drive; operands read zero outside ITER
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    angle_next   = angle_reg;
    target_next  = target_reg;
    select_next  = select_reg;
    iter_next    = iter_reg;
    start_ready  = 1'b0;
    valid        = 1'b0;
    res_valid    = 1'b0;
    x_init       = '0;
    y_init       = '0;
    x_shift      = '0;
    y_shift      = '0;
    angle        = '0;
    delta_angle  = '0;
    target_angle = '0;
    select       = '0;
    case (state_reg)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          x_next      = x_in;
          y_next      = y_in;
          target_next = target_in;
          select_next = select_in;
          angle_next  = '0;
          iter_next   = '0;
          state_next  = ST_ITER;
        end
      end
      ST_ITER: begin
        valid        = 1'b1;
        x_init       = x_reg;
        y_init       = y_reg;
        x_shift      = x_reg >>> iter_reg;
        y_shift      = y_reg >>> iter_reg;
        angle        = angle_reg;
        delta_angle  = atan_rom[iter_reg[4:0]];
        target_angle = target_reg;
        select       = select_reg;
        if (ALU_valid_out) begin
          x_next     = x_out;
          y_next     = y_out;
          angle_next = angle_out;
`ifdef CORDIC_EARLY_EXIT_EN
          // Exact hit: stop here and keep the index of the iteration that hit
          if (angle_out == target_reg) begin
            state_next = ST_DONE;
          end else begin
            iter_next = iter_reg + 6'd1;
            if (last_iter) state_next = ST_DONE;
          end
`else
          iter_next = iter_reg + 6'd1;
          if (last_iter) state_next = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
